// File: rtl/z80_pkg.sv
// z80_pkg: shared types and default wait-state constants for the Z80 bus-cycle sequencer
// Contents: cyc_type_t (requested machine cycle), bus_state_t (T-state), default wait counts
package z80_pkg;
  typedef enum logic [2:0] {FETCH, MEM_RD, MEM_WR, IO_RD, IO_WR} cyc_type_t;
  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4, BGNT} bus_state_t;
  localparam int MEM_WAIT_DEF = 0;
  localparam int IO_WAIT_DEF = 1;
endpackage

// File: rtl/z80_refresh_ctr.sv
// z80_refresh_ctr: Z80 R register with load, low-field increment and upper-bit preserve
// Ports: clk, rst_L (async active-low), inc (bump low RFSH_W bits), wr/wdata (load, wins over inc), r (current R)
module z80_refresh_ctr #(
  parameter int RFSH_W = 7
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       inc,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] r
);
  localparam logic [7:0] MASK = 8'((9'd1 << RFSH_W) - 9'd1);
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) r <= '0;
    else if (wr) r <= wdata;
    else if (inc) r <= (r & ~MASK) | ((r + 8'd1) & MASK);
endmodule

// File: rtl/z80_bus_cycle_gen.sv
// z80_bus_cycle_gen: Z80 machine-cycle sequencer (fetch/refresh, memory, IO, waits, bus hand-off)
// Core side: cyc_req/cyc_type/cyc_addr/cyc_wdata in, cyc_ready/cyc_ack/cyc_rdata out; i_reg, r_wr/r_wdata in, r_out out
// Pin side: data_in, WAIT_L, BUSREQ_L in; data_out/data_oe, addr_out/addr_oe, M1_L MREQ_L IORQ_L RD_L WR_L RFSH_L BUSACK_L out
module z80_bus_cycle_gen
  import z80_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MEM_WAIT = MEM_WAIT_DEF,
  parameter int IO_WAIT  = IO_WAIT_DEF,
  parameter int RFSH_W   = 7
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              cyc_req,
  input  cyc_type_t         cyc_type,
  input  logic [ADDR_W-1:0] cyc_addr,
  input  logic [DATA_W-1:0] cyc_wdata,
  output logic              cyc_ready,
  output logic              cyc_ack,
  output logic [DATA_W-1:0] cyc_rdata,
  input  logic [7:0]        i_reg,
  input  logic              r_wr,
  input  logic [7:0]        r_wdata,
  output logic [7:0]        r_out,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_oe,
  input  logic              WAIT_L,
  input  logic              BUSREQ_L,
  output logic              M1_L,
  output logic              MREQ_L,
  output logic              IORQ_L,
  output logic              RD_L,
  output logic              WR_L,
  output logic              RFSH_L,
  output logic              BUSACK_L
);
  bus_state_t state, nxt;
  cyc_type_t typ;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0] wcnt;
  logic fetch, io, rd, wr, last, hold, cap, op, act, late, refr;
  assign fetch = typ == FETCH;
  assign io = typ inside {IO_RD, IO_WR};
  assign rd = typ inside {FETCH, MEM_RD, IO_RD};
  assign wr = typ inside {MEM_WR, IO_WR};
  assign last = state == T4 || (state == T3 && !fetch);
  assign hold = wcnt != 8'd0 || !WAIT_L;
  assign cyc_ready = (state == IDLE || last) && BUSREQ_L;
  // opcode is latched at the end of the last T2/TW; other reads at the end of T3
  assign cap = rd && (fetch ? (state inside {T2, TW} && !hold) : state == T3);
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) state <= IDLE;
    else state <= nxt;
  // a pending bus request beats a new cycle request at every cycle boundary
  always_comb
    nxt = (state == IDLE || last) ? (!BUSREQ_L ? BGNT : cyc_req ? T1 : IDLE)
        : state == T1 ? T2
        : state inside {T2, TW} ? (hold ? TW : T3)
        : state == T3 ? T4
        : BUSREQ_L ? IDLE : BGNT;
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) begin
      typ <= FETCH;
      addr_q <= '0;
      wdata_q <= '0;
      wcnt <= '0;
      cyc_ack <= 1'b0;
      cyc_rdata <= '0;
    end else begin
      if (cyc_ready && cyc_req) begin
        typ <= cyc_type;
        addr_q <= cyc_addr;
        wdata_q <= cyc_wdata;
      end
      if (state == T1) wcnt <= 8'(io ? IO_WAIT : MEM_WAIT);
      else if (state inside {T2, TW} && wcnt != 8'd0) wcnt <= wcnt - 8'd1;
      cyc_ack <= last;
      if (cap) cyc_rdata <= data_in;
    end
  always_comb begin
    op = state inside {T1, T2, TW};
    act = state inside {T1, T2, TW, T3};
    late = state inside {T2, TW, T3};
    refr = fetch && state inside {T3, T4};
    M1_L = !(fetch && op);
    MREQ_L = !(!io && (act || state == T4));
    IORQ_L = !(io && late);
    RD_L = !(rd && (fetch ? op : act));
    WR_L = !(wr && late);
    RFSH_L = !refr;
    BUSACK_L = state != BGNT;
    data_oe = wr && act;
    addr_oe = state != BGNT;
    data_out = wdata_q;
    addr_out = refr ? ADDR_W'({i_reg, r_out}) : addr_q;
  end
  z80_refresh_ctr #(.RFSH_W(RFSH_W)) u_rfsh (
    .clk(clk),
    .rst_L(rst_L),
    .inc(state == T4),
    .wr(r_wr),
    .wdata(r_wdata),
    .r(r_out)
  );
endmodule

// File: tb/tb_z80_bus_cycle_gen.sv
// tb_z80_bus_cycle_gen: directed plus randomized checks of the Z80 bus-cycle sequencer against a cycle-length model
module tb_z80_bus_cycle_gen;
  import z80_pkg::*;
  localparam int MW = 0;
  localparam int IW = 1;
  localparam logic [8:0] IDLE_S = 9'b1111111_0_1;
  localparam logic [8:0] BGNT_S = 9'b1111110_0_0;
  logic clk = 0, rst_L = 1;
  logic cyc_req = 0;
  cyc_type_t cyc_type = FETCH;
  logic [15:0] cyc_addr = 0;
  logic [7:0] cyc_wdata = 0;
  logic cyc_ready, cyc_ack;
  logic [7:0] cyc_rdata;
  logic [7:0] i_reg = 0, r_wdata = 0, r_out;
  logic r_wr = 0;
  logic [7:0] data_in = 0, data_out;
  logic data_oe, addr_oe;
  logic [15:0] addr_out;
  logic WAIT_L = 1, BUSREQ_L = 1;
  logic M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L;
  int tests = 0, fails = 0;
  logic [7:0] r_m = 0, rd_m = 0;
  cyc_type_t nt = FETCH;
  logic [15:0] na = 0;
  logic [7:0] nwd = 0;
  int br_k = -1;
  bit rwr_fin = 0;
  logic [7:0] rwr_v = 0;

  z80_bus_cycle_gen #(.MEM_WAIT(MW), .IO_WAIT(IW)) dut (
    .clk(clk), .rst_L(rst_L), .cyc_req(cyc_req), .cyc_type(cyc_type), .cyc_addr(cyc_addr),
    .cyc_wdata(cyc_wdata), .cyc_ready(cyc_ready), .cyc_ack(cyc_ack), .cyc_rdata(cyc_rdata),
    .i_reg(i_reg), .r_wr(r_wr), .r_wdata(r_wdata), .r_out(r_out), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .addr_out(addr_out), .addr_oe(addr_oe),
    .WAIT_L(WAIT_L), .BUSREQ_L(BUSREQ_L), .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
    .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L), .BUSACK_L(BUSACK_L)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] strb();
    return {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L, data_oe, addr_oe};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input cyc_type_t t, input logic [15:0] a, input logic [7:0] wd);
    cyc_req = 1;
    cyc_type = t;
    cyc_addr = a;
    cyc_wdata = wd;
    chk("ready_at_issue", cyc_ready, 1);
    step();
    cyc_req = 0;
    cyc_type = cyc_type_t'(3'($urandom_range(0, 4)));
    cyc_addr = 16'($urandom);
    cyc_wdata = 8'($urandom);
  endtask

  // expected pin activity from the cycle length: T1, T2, n waits, T3 (+T4 for fetch)
  task automatic run(input cyc_type_t t, input logic [15:0] a, input logic [7:0] wd,
                     input logic [7:0] din, input int e, input bit chain);
    bit f, io, rd, wr;
    int w, n, tot, cap;
    logic m1, mr, iq, rdl, wrl, rf, doe;
    logic [15:0] ea;
    f = t == FETCH;
    io = t inside {IO_RD, IO_WR};
    rd = t inside {FETCH, MEM_RD, IO_RD};
    wr = t inside {MEM_WR, IO_WR};
    w = io ? IW : MW;
    n = w > e ? w : e;
    tot = (f ? 4 : 3) + n;
    cap = f ? n + 1 : n + 2;
    for (int k = 0; k < tot; k++) begin
      if (k == br_k) BUSREQ_L = 0;
      m1 = 1; mr = 1; iq = 1; rdl = 1; wrl = 1; rf = 1; doe = 0; ea = a;
      if (f) begin
        if (k <= n + 1) begin m1 = 0; mr = 0; rdl = 0; end
        else begin rf = 0; mr = 0; ea = {i_reg, r_m}; end
      end else begin
        if (io) iq = k == 0;
        else mr = 0;
        if (rd) rdl = 0;
        if (wr) begin wrl = k == 0; doe = 1; end
      end
      chk("strobes", strb(), {m1, mr, iq, rdl, wrl, rf, 1'b1, doe, 1'b1});
      chk("addr", addr_out, ea);
      if (wr) chk("wdata", data_out, wd);
      if (k > 0) chk("ack_low", cyc_ack, 0);
      chk("ready", cyc_ready, (k == tot - 1) && BUSREQ_L);
      data_in = k == cap ? din : 8'($urandom);
      WAIT_L = (k >= 1 && k <= n + 1) ? (k > e) : 1'($urandom);
      if (k == tot - 1 && chain) begin
        cyc_req = 1; cyc_type = nt; cyc_addr = na; cyc_wdata = nwd;
      end
      if (k == tot - 1 && rwr_fin) begin r_wr = 1; r_wdata = rwr_v; end
      step();
      cyc_req = 0;
      r_wr = 0;
    end
    WAIT_L = 1;
    if (rd) rd_m = din;
    if (f) r_m = rwr_fin ? rwr_v : {r_m[7], 7'(r_m[6:0] + 7'd1)};
    rwr_fin = 0;
    chk("ack", cyc_ack, 1);
    chk("rdata", cyc_rdata, rd_m);
    chk("r", r_out, r_m);
  endtask

  initial begin
    cyc_type_t t;
    logic [15:0] a;
    logic [7:0] wd, din;
    #2 rst_L = 0;
    step();
    step();
    chk("rst_strobes", strb(), IDLE_S);
    chk("rst_addr", addr_out, 0);
    chk("rst_ack", cyc_ack, 0);
    chk("rst_rdata", cyc_rdata, 0);
    chk("rst_r", r_out, 0);
    chk("rst_ready", cyc_ready, 1);
    @(negedge clk);
    rst_L = 1;
    // fetch with refresh address and R wrap keeping bit 7
    r_wr = 1; r_wdata = 8'h7F;
    step();
    r_wr = 0; r_m = 8'h7F;
    chk("r_load", r_out, 8'h7F);
    i_reg = 8'h80;
    issue(FETCH, 16'h1234, 8'h00);
    run(FETCH, 16'h1234, 8'h00, 8'h04, 0, 0);
    chk("r_wrap", r_out, 8'h00);
    // memory write stretched by two external waits
    issue(MEM_WR, 16'h4000, 8'hAA);
    run(MEM_WR, 16'h4000, 8'hAA, 8'h00, 2, 0);
    step();
    chk("idle_after_wr", strb(), IDLE_S);
    chk("ack_single", cyc_ack, 0);
    // IO read with its automatic wait
    issue(IO_RD, 16'h00FE, 8'h00);
    run(IO_RD, 16'h00FE, 8'h00, 8'h5A, 0, 0);
    // back-to-back fetch then memory read
    nt = MEM_RD; na = 16'h2345; nwd = 8'h00;
    issue(FETCH, 16'h0100, 8'h00);
    run(FETCH, 16'h0100, 8'h00, 8'h3C, 0, 1);
    run(MEM_RD, 16'h2345, 8'h00, 8'hC3, 0, 0);
    // R load on the last fetch edge wins over the increment
    rwr_fin = 1; rwr_v = 8'hD5;
    issue(FETCH, 16'h0200, 8'h00);
    run(FETCH, 16'h0200, 8'h00, 8'h11, 1, 0);
    // bus request raised mid-cycle is honoured only after the cycle ends
    br_k = 1;
    issue(MEM_RD, 16'h5555, 8'h00);
    run(MEM_RD, 16'h5555, 8'h00, 8'h99, 0, 0);
    br_k = -1;
    chk("bgnt_strobes", strb(), BGNT_S);
    cyc_req = 1; cyc_type = FETCH;
    step();
    chk("bgnt_hold", strb(), BGNT_S);
    chk("bgnt_ready", cyc_ready, 0);
    chk("bgnt_ack", cyc_ack, 0);
    cyc_req = 0;
    BUSREQ_L = 1;
    step();
    chk("bgnt_release", strb(), IDLE_S);
    // reset in the middle of a write
    issue(MEM_WR, 16'h2222, 8'h33);
    step();
    chk("wr_t2", WR_L, 0);
    #2 rst_L = 0;
    #1;
    chk("mid_rst_strobes", strb(), IDLE_S);
    chk("mid_rst_addr", addr_out, 0);
    chk("mid_rst_rdata", cyc_rdata, 0);
    chk("mid_rst_r", r_out, 0);
    r_m = 0; rd_m = 0;
    @(negedge clk);
    rst_L = 1;
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      t = cyc_type_t'(3'($urandom_range(0, 4)));
      a = 16'($urandom);
      wd = 8'($urandom);
      din = 8'($urandom);
      i_reg = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r_wr = 1; r_wdata = 8'($urandom);
        r_m = r_wdata;
        step();
        r_wr = 0;
        chk("rand_r_load", r_out, r_m);
      end
      issue(t, a, wd);
      run(t, a, wd, din, int'($urandom_range(0, 3)), 0);
      if ($urandom_range(0, 1) == 1) begin
        step();
        chk("rand_idle", strb(), IDLE_S);
        chk("rand_idle_ack", cyc_ack, 0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
